// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM dead-time stage: FSM state encoding and default widths.
package pwm_pkg;

  localparam int DT_BITS_DEFAULT = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_OFF  = 3'd0;
  localparam state_t S_LO   = 3'd1;
  localparam state_t S_DT_H = 3'd2;
  localparam state_t S_HI   = 3'd3;
  localparam state_t S_DT_L = 3'd4;

endpackage

// File: rtl/pwm_dt_counter.sv
// Dead-interval counter: load latches the length and restarts the count; done flags the
// last cycle of the interval (count == length-1).
module pwm_dt_counter
  import pwm_pkg::*;
#(
  parameter int DT_BITS = DT_BITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DT_BITS-1:0] length,
  output logic               done,
  output logic               active
);

  localparam logic [DT_BITS-1:0] ONE = {{(DT_BITS-1){1'b0}}, 1'b1};

  logic [DT_BITS-1:0] count;
  logic [DT_BITS-1:0] lat;

  assign done = active && (count == (lat - ONE));

  // Count stops on completion, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      lat    <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= '0;
      lat    <= length;
      active <= 1'b1;
    end else if (done) begin
      active <= 1'b0;
    end else if (active) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary half-bridge gate driver with programmable dead time.
// Optional fault latch enabled by defining PWM_DT_FAULT_LATCH_EN.
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int DT_BITS = DT_BITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pwm_in,
  input  logic [DT_BITS-1:0] dead_time,
  output logic               pwm_hi,
  output logic               pwm_lo,
  output logic               dt_active
`ifdef PWM_DT_FAULT_LATCH_EN
  ,
  input  logic               fault,
  input  logic               fault_clr,
  output logic               fault_latched
`endif
);

  state_t state;
  state_t nxt;
  logic   pwm_q;
  logic   load;
  logic   dt_zero;
  logic   cnt_done;
  logic   cnt_active;
  logic   halt;

`ifdef PWM_DT_FAULT_LATCH_EN
  logic fault_m;
  logic fault_s;

  // Two-flop synchronizer and sticky fault latch; clear only once the fault is gone.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_m       <= 1'b0;
      fault_s       <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      fault_m <= fault;
      fault_s <= fault_m;
      if (fault_s) begin
        fault_latched <= 1'b1;
      end else if (fault_clr) begin
        fault_latched <= 1'b0;
      end else begin
        fault_latched <= fault_latched;
      end
    end
  end

  assign halt = fault_s | fault_latched;
`else
  assign halt = 1'b0;
`endif

  assign dt_zero = (dead_time == '0);

  pwm_dt_counter #(.DT_BITS(DT_BITS)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .length (dead_time),
    .done   (cnt_done),
    .active (cnt_active)
  );

  // Next-state logic; a zero dead time bypasses the dead states entirely.
  always_comb begin
    nxt = state;
    if (!enable || halt) begin
      nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:   nxt = pwm_q ? (dt_zero ? S_HI : S_DT_H) : (dt_zero ? S_LO : S_DT_L);
        S_LO:    nxt = pwm_q ? (dt_zero ? S_HI : S_DT_H) : S_LO;
        S_HI:    nxt = pwm_q ? S_HI : (dt_zero ? S_LO : S_DT_L);
        S_DT_H: begin
          if (!pwm_q)                       nxt = S_LO;
          else if (cnt_active && cnt_done) nxt = S_HI;
          else                              nxt = S_DT_H;
        end
        S_DT_L: begin
          if (pwm_q)                        nxt = S_HI;
          else if (cnt_active && cnt_done) nxt = S_LO;
          else                              nxt = S_DT_L;
        end
        default: nxt = S_OFF;
      endcase
    end
  end

  assign load = ((nxt == S_DT_H) || (nxt == S_DT_L)) && (nxt != state);

  // State, input sample and outputs decoded from next state so they change with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_OFF;
      pwm_q     <= 1'b0;
      pwm_hi    <= 1'b0;
      pwm_lo    <= 1'b0;
      dt_active <= 1'b0;
    end else begin
      state     <= nxt;
      pwm_q     <= pwm_in;
      pwm_hi    <= (nxt == S_HI);
      pwm_lo    <= (nxt == S_LO);
      dt_active <= (nxt == S_DT_H) || (nxt == S_DT_L);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed self-checking bench for pwm_deadtime_gen; fault section built with PWM_DT_FAULT_LATCH_EN.
module tb_pwm_deadtime_gen;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pwm_in;
  logic [7:0] dead_time;
  logic       pwm_hi;
  logic       pwm_lo;
  logic       dt_active;
`ifdef PWM_DT_FAULT_LATCH_EN
  logic       fault;
  logic       fault_clr;
  logic       fault_latched;
`endif

  int checks   = 0;
  int failures = 0;

  pwm_deadtime_gen #(.DT_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .dead_time (dead_time),
    .pwm_hi    (pwm_hi),
    .pwm_lo    (pwm_lo),
    .dt_active (dt_active)
`ifdef PWM_DT_FAULT_LATCH_EN
    ,
    .fault         (fault),
    .fault_clr     (fault_clr),
    .fault_latched (fault_latched)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic hi, input logic lo, input logic dt);
    check_eq({tag, "_hi"}, pwm_hi, hi);
    check_eq({tag, "_lo"}, pwm_lo, lo);
    check_eq({tag, "_dt"}, dt_active, dt);
  endtask

  // Drive pwm_in to v and check the full dead-interval sequence of length dt (dt > 0).
  task automatic run_edge(input logic v, input int dt);
    pwm_in = v;
    step();
    check_outs("edge_hold", ~v, v, 1'b0);
    step();
    check_outs("edge_dt_start", 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < dt; i++) begin
      step();
      check_outs("edge_dt_mid", 1'b0, 1'b0, 1'b1);
    end
    step();
    check_outs("edge_drive", v, ~v, 1'b0);
  endtask

  // pwm_in goes to v for three samples only, with a long dead time: must abort back.
  task automatic abort_check(input logic v);
    pwm_in = v;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("abort_no_drive", v ? pwm_hi : pwm_lo, 1'b0);
      if (i == 2) pwm_in = ~v;
    end
    step();
    check_outs("abort_return", ~v, v, 1'b0);
  endtask

  always @(negedge clk) begin
    check_eq("no_overlap", pwm_hi & pwm_lo, 1'b0);
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    pwm_in    = 1'b1;
    dead_time = 8'd4;
`ifdef PWM_DT_FAULT_LATCH_EN
    fault     = 1'b0;
    fault_clr = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("reset", 1'b0, 1'b0, 1'b0);
    end

    // Release with enable low for one edge so pwm_q settles, then enable.
    reset  = 1'b0;
    enable = 1'b0;
    step();
    check_outs("post_reset_idle", 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    check_outs("start_dt", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("start_dt_mid", 1'b0, 1'b0, 1'b1);
    end
    step();
    check_outs("start_hi", 1'b1, 1'b0, 1'b0);

    // Basic dead time 4 on both edges.
    run_edge(1'b0, 4);
    run_edge(1'b1, 4);

    // Aborts from the high side, then from the low side.
    dead_time = 8'd10;
    abort_check(1'b0);
    dead_time = 8'd2;
    run_edge(1'b0, 2);
    dead_time = 8'd10;
    abort_check(1'b1);

    // Zero dead time: direct complementary switching.
    dead_time = 8'd0;
    for (int t = 0; t < 4; t++) begin
      pwm_in = (t % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < 5; c++) begin
        step();
        check_eq("zdt_compl", pwm_hi, ~pwm_lo);
        check_eq("zdt_no_dt", dt_active, 1'b0);
      end
      check_eq("zdt_track", pwm_hi, pwm_in);
    end

    // Enable dropped during a dead interval before high.
    dead_time = 8'd4;
    pwm_in    = 1'b1;
    step();
    step();
    check_outs("en_dt", 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    step();
    check_outs("en_off", 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    check_outs("en_restart_dt", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("en_restart_mid", 1'b0, 1'b0, 1'b1);
    end
    step();
    check_outs("en_restart_hi", 1'b1, 1'b0, 1'b0);

    // dead_time changed mid-interval: current stays 4, next uses 8.
    pwm_in = 1'b0;
    step();
    step();
    check_outs("chg_dt_start", 1'b0, 1'b0, 1'b1);
    dead_time = 8'd8;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("chg_dt_mid", 1'b0, 1'b0, 1'b1);
    end
    step();
    check_outs("chg_dt_lo", 1'b0, 1'b1, 1'b0);
    run_edge(1'b1, 8);

`ifdef PWM_DT_FAULT_LATCH_EN
    // Fault during S_HI, ignored clear, then valid clear and full dead interval.
    fault = 1'b1;
    step();
    step();
    step();
    check_eq("fault_hi_off", pwm_hi, 1'b0);
    check_eq("fault_latched_set", fault_latched, 1'b1);
    fault_clr = 1'b1;
    step();
    check_eq("fault_clr_ignored", fault_latched, 1'b1);
    fault_clr = 1'b0;
    fault     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("fault_still_latched", fault_latched, 1'b1);
      check_outs("fault_off", 1'b0, 1'b0, 1'b0);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check_eq("fault_cleared", fault_latched, 1'b0);
    check_outs("fault_clr_off", 1'b0, 1'b0, 1'b0);
    step();
    check_outs("fault_resume_dt", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step();
      check_outs("fault_resume_mid", 1'b0, 1'b0, 1'b1);
    end
    step();
    check_outs("fault_resume_hi", 1'b1, 1'b0, 1'b0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
